// File: rtl/hamming74_decoder.sv
// hamming74_decoder: serial Hamming(7,4) decoder with single-error correction and framing checks.
// Define HAMDEC_ERRCNT_EN to add the saturating corrected-error counter (err_count, cnt_clr).
module hamming74_decoder #(
    parameter bit MSB_FIRST = 1'b1
`ifdef HAMDEC_ERRCNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       sof,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic [2:0] syndrome,
    output logic       err_corrected,
    output logic       frame_err
`ifdef HAMDEC_ERRCNT_EN
    , input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_count
`endif
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] sr_q, sr_d, word;
    logic [2:0] syn;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_data_q, out_data_d;
    logic [2:0] syndrome_q, syndrome_d;
    logic       err_corrected_q, err_corrected_d;
    logic       frame_err_q, frame_err_d;
    always_comb begin
        word = MSB_FIRST ? {sr_q[5:0], in_bit} : {in_bit, sr_q[6:1]};
        syn = {word[1] ^ word[2] ^ word[3] ^ word[6],
               word[0] ^ word[1] ^ word[2] ^ word[5],
               word[0] ^ word[2] ^ word[3] ^ word[4]};
        state_d = state_q;
        cnt_d = cnt_q;
        sr_d = sr_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        out_data_d = out_data_q;
        syndrome_d = syndrome_q;
        err_corrected_d = err_corrected_q;
        if (in_valid && sof) begin
            // any sof restarts framing; a word in progress is abandoned
            frame_err_d = (state_q == SHIFT);
            sr_d = MSB_FIRST ? {6'd0, in_bit} : {in_bit, 6'd0};
            cnt_d = 3'd1;
            state_d = SHIFT;
        end else if (in_valid && state_q == SHIFT) begin
            sr_d = word;
            if (cnt_q == 3'd6) begin
                cnt_d = 3'd0;
                state_d = IDLE;
                out_valid_d = 1'b1;
                out_data_d = word[3:0] ^ {syn == 3'd5, syn == 3'd7, syn == 3'd6, syn == 3'd3};
                syndrome_d = syn;
                err_corrected_d = |syn;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= 3'd0;
            sr_q <= 7'd0;
            out_valid_q <= 1'b0;
            out_data_q <= 4'd0;
            syndrome_q <= 3'd0;
            err_corrected_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sr_q <= sr_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            syndrome_q <= syndrome_d;
            err_corrected_q <= err_corrected_d;
            frame_err_q <= frame_err_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign syndrome = syndrome_q;
    assign err_corrected = err_corrected_q;
    assign frame_err = frame_err_q;
`ifdef HAMDEC_ERRCNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;
    always_comb begin
        err_count_d = cnt_clr ? '0
                    : (out_valid_d && err_corrected_d && !(&err_count_q)) ? err_count_q + CNT_W'(1)
                    : err_count_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count_q <= '0;
        else err_count_q <= err_count_d;
    end
    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_hamming74_decoder.sv
// tb_hamming74_decoder: randomized bench for hamming74_decoder (MSB-first default build),
// checked every cycle against a nearest-codeword reference model.
module tb_hamming74_decoder;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_bit = 1'b0, sof = 1'b0;
    logic out_valid, err_corrected, frame_err;
    logic [3:0] out_data;
    logic [2:0] syndrome;
    int checks = 0, errors = 0;
    bit active = 1'b0;
    bit bits[$];
    logic [3:0] e_data = 4'd0;
    logic [2:0] e_syn = 3'd0;
    logic e_err = 1'b0;
    localparam logic [20:0] COLS = {3'd4, 3'd2, 3'd1, 3'd5, 3'd7, 3'd6, 3'd3};
`ifdef HAMDEC_ERRCNT_EN
    logic cnt_clr = 1'b0;
    logic [15:0] err_count;
    int ecnt = 0;
`endif

    hamming74_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .sof(sof),
        .out_valid(out_valid), .out_data(out_data), .syndrome(syndrome),
        .err_corrected(err_corrected), .frame_err(frame_err)
`ifdef HAMDEC_ERRCNT_EN
        , .cnt_clr(cnt_clr), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[1] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2], d[0] ^ d[2] ^ d[3], d};
    endfunction

    function automatic logic [2:0] syn_of(input logic [6:0] w);
        logic [2:0] s = 3'd0;
        for (int i = 0; i < 7; i++) if (w[i]) s ^= COLS[3*i +: 3];
        return s;
    endfunction

    function automatic logic [3:0] nearest(input logic [6:0] w);
        for (int d = 0; d < 16; d++)
            if ($countones(encode(4'(d)) ^ w) <= 1) return 4'(d);
        return 4'd0;
    endfunction

    task automatic cyc(input logic v, input logic s, input logic b);
        logic ov, fe;
        logic [6:0] w;
        ov = 1'b0;
        fe = 1'b0;
        in_valid = v;
        sof = s;
        in_bit = b;
        if (v) begin
            if (s) begin
                fe = active;
                bits.delete();
                bits.push_back(b);
                active = 1'b1;
            end else if (active) begin
                bits.push_back(b);
                if (bits.size() == 7) begin
                    w = 7'd0;
                    foreach (bits[i]) w = {w[5:0], bits[i]};
                    ov = 1'b1;
                    active = 1'b0;
                    e_data = nearest(w);
                    e_syn = syn_of(w);
                    e_err = (w != encode(w[3:0]));
                end
            end
        end
`ifdef HAMDEC_ERRCNT_EN
        if (cnt_clr) ecnt = 0;
        else if (ov && e_err && ecnt < 65535) ecnt++;
`endif
        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, ov);
        check("frame_err", frame_err, fe);
        check("out_data", out_data, e_data);
        check("syndrome", syndrome, e_syn);
        check("err_corrected", err_corrected, e_err);
`ifdef HAMDEC_ERRCNT_EN
        check("err_count", err_count, ecnt);
`endif
        in_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic send_part(input logic [6:0] w, input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, k == 0, w[6-k]);
    endtask

    task automatic send_word(input logic [6:0] w, input int gap_pct);
        for (int k = 0; k < 7; k++) begin
            if (k > 0 && $urandom_range(0, 99) < gap_pct)
                repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b0, 1'($urandom));
            cyc(1'b1, k == 0, w[6-k]);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ov"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_syn"}, syndrome, 0);
        check({tag, "_err"}, err_corrected, 0);
        check({tag, "_fe"}, frame_err, 0);
`ifdef HAMDEC_ERRCNT_EN
        check({tag, "_cnt"}, err_count, 0);
`endif
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        send_word(7'h0B, 0);
        check("clean_ov", out_valid, 1);
        check("clean_data", out_data, 4'hB);
        check("clean_syn", syndrome, 3'b000);
        check("clean_err", err_corrected, 0);
        send_word(7'h0F, 0);
        check("data_err_data", out_data, 4'hB);
        check("data_err_syn", syndrome, 3'b111);
        check("data_err_err", err_corrected, 1);
        send_word(7'h71, 0);
        check("par_err_data", out_data, 4'h1);
        check("par_err_syn", syndrome, 3'b100);
        check("par_err_err", err_corrected, 1);
        send_part(7'h55, 4);
        send_word(7'h31, 0);
        check("frame_data", out_data, 4'h1);
        repeat (3) cyc(1'b1, 1'b0, 1'b1);
        send_part(7'h2A, 6);
        send_word(encode(4'h6), 0);
        check("sof7_data", out_data, 4'h6);
        send_word(encode(4'h9), 60);
        send_word(encode(4'hC), 60);
        check("b2b_data", out_data, 4'hC);
        send_part(7'h31, 3);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        active = 1'b0;
        bits.delete();
        e_data = 4'd0;
        e_syn = 3'd0;
        e_err = 1'b0;
`ifdef HAMDEC_ERRCNT_EN
        ecnt = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
`ifdef HAMDEC_ERRCNT_EN
        send_word(encode(4'h3) ^ 7'h04, 0);
        send_word(encode(4'hA) ^ 7'h40, 0);
        send_word(encode(4'h7) ^ 7'h01, 0);
        check("cnt_three", err_count, 3);
        cnt_clr = 1'b1;
        send_word(encode(4'h5) ^ 7'h10, 0);
        cnt_clr = 1'b0;
        check("cnt_clr", err_count, 0);
`endif
        repeat (80) begin
            case ($urandom_range(0, 9))
                0: repeat ($urandom_range(1, 3)) cyc(1'b1, 1'b0, 1'($urandom));
                1: send_part(7'($urandom), $urandom_range(1, 6));
                default: send_word(7'($urandom), 30);
            endcase
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming74_decoder.md
Name: hamming74_decoder

Overview:
Serial-in Hamming(7,4) decoder and single-error corrector. It sits directly downstream of the team's serial Hamming(7,4) encoder.
- Accepts the 7-bit codeword stream one bit per qualified clock.
- Computes the 3-bit syndrome and corrects any single-bit error.
- Presents the 4-bit data word with status flags as a registered one-cycle strobe.

Parameters:
MSB_FIRST, 1, 1: first received bit is r[6]; 0: first received bit is r[0].
CNT_W, 16, width of the optional corrected-error counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial codeword bit
sof  input  1  start-of-frame; qualified by in_valid; marks bit 0 of a codeword
out_valid  output  1  one-cycle strobe: decoded word available
out_data  output  4  corrected data d3..d0
syndrome  output  3  syndrome {s2,s1,s0} of the emitted word
err_corrected  output  1  nonzero syndrome; one bit was corrected
frame_err  output  1  one-cycle pulse: sof arrived mid-word, partial word dropped
err_count  output  CNT_W  corrected-error count (present only with the macro)
cnt_clr  input  1  synchronous clear of err_count (present only with the macro)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, all of the following are 0: out_valid, out_data, syndrome, err_corrected, frame_err, err_count, the bit counter and the shift register; the FSM is in IDLE.
- Codeword format: r[3:0] = d3..d0; r[6:4] = p2,p1,p0.
  - p0 = d0^d2^d3; p1 = d0^d1^d2; p2 = d1^d2^d3 (systematic cyclic code, g(x)=x^3+x+1).
- Syndrome: s = {p2'^r6, p1'^r5, p0'^r4}, where p' is parity recomputed from the received r[3:0].
- Correction map (flip the listed bit, else no change):
  - s=011 → r0; s=110 → r1; s=111 → r2; s=101 → r3
  - s=001 → r4; s=010 → r5; s=100 → r6
  - s=000 → no error
- Parity-bit errors leave out_data unchanged but still set err_corrected=1.
- FSM states: IDLE, SHIFT.
  - IDLE: in_valid=1 & sof=0 → bit discarded, stay in IDLE.
  - IDLE: in_valid=1 & sof=1 → capture bit 0, bit counter = 1, go to SHIFT.
  - SHIFT: in_valid=1 & sof=0 → shift bit in, bit counter +1.
  - SHIFT: in_valid=0 → hold all state (gaps allowed, no timeout).
  - SHIFT: on the 7th bit (counter==6 and in_valid=1) → word complete; counter = 0; go to IDLE.
  - Syndrome may be computed serially (LFSR) or in parallel at completion; only the registered result is specified.
- Output timing: out_valid=1 for exactly one cycle, the cycle after the 7th bit is accepted.
  - out_data, syndrome and err_corrected update in that same cycle and hold until the next word.
  - Latency is 1 clk from the last bit to out_valid.
- Back-to-back words: sof on the cycle immediately after the 7th bit starts a new word. No bubble is required.
- sof during SHIFT (counter 1..6):
  - Partial word is dropped; frame_err pulses 1 cycle later.
  - The sof bit becomes bit 0 of the new word; counter = 1; stay in SHIFT.
  - No out_valid for the dropped word.
- sof coincident with the 7th bit slot (counter==6): treated as mid-word sof. The 7th bit is not taken, frame_err pulses, and the new word starts.
- Reset mid-word: partial word lost, no out_valid, FSM returns to IDLE.

Optional Feature:
HAMDEC_ERRCNT_EN
- Defined:
  - err_count and cnt_clr ports exist.
  - err_count increments by 1 in the same cycle out_valid=1 with err_corrected=1.
  - Saturates at all-ones; no wrap.
  - cnt_clr=1 forces 0 on the next edge; cnt_clr has priority over a simultaneous increment.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Clean word: sof+7'h0B sent MSB-first (0,0,0,1,0,1,1) → 1 clk after the last bit: out_valid=1, out_data=4'hB, syndrome=000, err_corrected=0.
- Data error: send 7'h0F (7'h0B with r2 flipped) → out_data=4'hB, syndrome=111, err_corrected=1.
- Parity error: send 7'h71 (valid 7'h31 with r6 flipped) → out_data=4'h1, syndrome=100, err_corrected=1.
- Framing:
  - 4 bits, then sof with a full 7'h31 → frame_err pulses once; one out_valid with out_data=4'h1.
  - Bits with in_valid=1 and no sof while in IDLE → no output.
- Gaps and back-to-back: in_valid=0 gaps inside a word, then the next sof immediately after the 7th bit → two out_valid strobes, correct data for both.
- Reset and counter:
  - rst_n low mid-word → no out_valid; all outputs 0.
  - With HAMDEC_ERRCNT_EN defined: 3 corrupted words → err_count=3.
  - cnt_clr asserted together with a corrupted word → err_count=0.
